// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - binary32 field layout and special encodings shared by the add/sub/compare unit
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;
  localparam logic [31:0] FP32_NINF = 32'hFF800000;
  localparam int          EXP_BIAS  = 127;

endpackage

// File: rtl/floating_point_add_sub_comp_if.sv
// rtl/floating_point_add_sub_comp_if.sv - operand/result bundle of the FPU add/sub/compare unit
interface floating_point_add_sub_comp_if;

  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        comp;
  logic [31:0] y;
  logic        a_hi_b;
  logic        a_equal_b;

  modport master (output a, b, sub, comp, input y, a_hi_b, a_equal_b);
  modport slave  (input a, b, sub, comp, output y, a_hi_b, a_equal_b);

endinterface

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - 28-bit leading-zero counter (28 when the input is all zeros)
module fpu_lzc (
  input  logic [27:0] data_i,
  output logic [4:0]  count_o
);

  // Ascending scan: the highest set bit is the last one written.
  always_comb begin
    count_o = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (data_i[i]) count_o = 5'(27 - i);
    end
  end

endmodule

// File: rtl/floating_point_add_sub_comp.sv
// rtl/floating_point_add_sub_comp.sv - binary32 add/sub (FTZ, RNE) with magnitude compare
// Optional output register stage enabled by FPU_ADDSUB_OUT_REG_EN.
module floating_point_add_sub_comp
  import fpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_a,
  input  logic [31:0] io_b,
  input  logic        io_sub,
  input  logic        io_comp,
  output logic [31:0] io_y,
  output logic        io_a_hi_b,
  output logic        io_a_equal_b
);

  fp32_t a, b;
  assign a = io_a;
  assign b = io_b;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign a_zero = (a.exp == 8'h00);
  assign b_zero = (b.exp == 8'h00);
  assign a_inf  = (a.exp == 8'hFF) && (a.frac == 23'h0);
  assign b_inf  = (b.exp == 8'hFF) && (b.frac == 23'h0);
  assign a_nan  = (a.exp == 8'hFF) && (a.frac != 23'h0);
  assign b_nan  = (b.exp == 8'hFF) && (b.frac != 23'h0);

  // Compare mode always evaluates A - B on the sum path.
  logic sign_b;
  assign sign_b = b.sign ^ (io_sub | io_comp);

  logic [30:0] mag_a, mag_b;
  logic        a_ge_b;
  assign mag_a  = a_zero ? 31'h0 : io_a[30:0];
  assign mag_b  = b_zero ? 31'h0 : io_b[30:0];
  assign a_ge_b = (mag_a >= mag_b);

  logic [23:0] man_a, man_b, man_l, man_s;
  logic [7:0]  exp_l, exp_s, exp_diff;
  logic        sign_l, eff_sub;
  assign man_a    = a_zero ? 24'h0 : {1'b1, a.frac};
  assign man_b    = b_zero ? 24'h0 : {1'b1, b.frac};
  assign man_l    = a_ge_b ? man_a : man_b;
  assign man_s    = a_ge_b ? man_b : man_a;
  assign exp_l    = a_ge_b ? a.exp : b.exp;
  assign exp_s    = a_ge_b ? b.exp : a.exp;
  assign sign_l   = a_ge_b ? a.sign : sign_b;
  assign eff_sub  = a.sign ^ sign_b;
  assign exp_diff = exp_l - exp_s;

  // Aligned operands carry {mantissa, guard, round, sticky}.
  logic [49:0] shifted;
  logic [26:0] al_l, al_s;
  assign shifted = {man_s, 26'h0} >> exp_diff;
  assign al_l    = {man_l, 3'b000};
  assign al_s    = (exp_diff >= 8'd26) ? {26'h0, |man_s} : {shifted[49:24], |shifted[23:0]};

  logic [27:0] sum;
  assign sum = eff_sub ? ({1'b0, al_l} - {1'b0, al_s}) : ({1'b0, al_l} + {1'b0, al_s});

  logic [4:0] lz;
  fpu_lzc u_lzc (
    .data_i  (sum),
    .count_o (lz)
  );

  // lz == 0 is the carry-out case; one formula covers right and left renormalization.
  logic [26:0]       norm;
  logic signed [9:0] exp_n;
  assign norm  = sum[27] ? {sum[27:2], |sum[1:0]} : (sum[26:0] << (lz - 5'd1));
  assign exp_n = $signed({2'b00, exp_l}) + 10'sd1 - $signed({5'b00000, lz});

  logic              round_up;
  logic [24:0]       man_rnd;
  logic signed [9:0] exp_r;
  logic [22:0]       frac_r;
  assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign man_rnd  = {1'b0, norm[26:3]} + {24'h0, round_up};
  assign exp_r    = exp_n + $signed({9'h0, man_rnd[24]});
  assign frac_r   = man_rnd[24] ? man_rnd[23:1] : man_rnd[22:0];

  logic [31:0] y_d;
  always_comb begin
    y_d = {sign_l, exp_r[7:0], frac_r};
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) y_d = FP32_QNAN;
    else if (a_inf)                                    y_d = a.sign ? FP32_NINF : FP32_PINF;
    else if (b_inf)                                    y_d = sign_b ? FP32_NINF : FP32_PINF;
    else if (sum == 28'h0)                             y_d = {a.sign & sign_b, 31'h0};
    else if (exp_r >= 10'sd255)                        y_d = sign_l ? FP32_NINF : FP32_PINF;
    else if (exp_r <= 10'sd0)                          y_d = {sign_l, 31'h0};
  end

  // Zeros compare as unsigned zero so that +0 == -0.
  logic cmp_sa, cmp_sb, eq_raw, gt_raw, hi_d, eq_d;
  assign cmp_sa = a.sign & ~a_zero;
  assign cmp_sb = b.sign & ~b_zero;
  assign eq_raw = (io_a == io_b) || (a_zero && b_zero);
  assign gt_raw = (cmp_sa != cmp_sb) ? cmp_sb : (cmp_sa ? (mag_a < mag_b) : (mag_a > mag_b));
  assign eq_d   = io_comp & ~a_nan & ~b_nan & eq_raw;
  assign hi_d   = io_comp & ~a_nan & ~b_nan & ~eq_raw & gt_raw;

`ifdef FPU_ADDSUB_OUT_REG_EN
  logic [31:0] y_q;
  logic        hi_q, eq_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      y_q  <= 32'h0;
      hi_q <= 1'b0;
      eq_q <= 1'b0;
    end else begin
      y_q  <= y_d;
      hi_q <= hi_d;
      eq_q <= eq_d;
    end
  end
  assign io_y         = y_q;
  assign io_a_hi_b    = hi_q;
  assign io_a_equal_b = eq_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ reset;
  assign io_y           = y_d;
  assign io_a_hi_b      = hi_d;
  assign io_a_equal_b   = eq_d;
`endif

endmodule

// File: tb/tb_floating_point_add_sub_comp.sv
// tb/tb_floating_point_add_sub_comp.sv - directed and random checks of the add/sub/compare unit against a real-arithmetic model
module tb_floating_point_add_sub_comp;
  import fpu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  floating_point_add_sub_comp_if fpu_if ();

  floating_point_add_sub_comp dut (
    .clock        (clock),
    .reset        (reset),
    .io_a         (fpu_if.a),
    .io_b         (fpu_if.b),
    .io_sub       (fpu_if.sub),
    .io_comp      (fpu_if.comp),
    .io_y         (fpu_if.y),
    .io_a_hi_b    (fpu_if.a_hi_b),
    .io_a_equal_b (fpu_if.a_equal_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'h0);
  endfunction

  function automatic bit is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 23'h0);
  endfunction

  // Flush-to-zero value of a binary32 as a double.
  function automatic real to_real(input logic [31:0] v);
    logic [63:0] d;
    if (v[30:23] == 8'h00) return 0.0;
    if (v[30:23] == 8'hFF) d = {v[31], 11'h7FF, 52'h0};
    else                   d = {v[31], 11'(int'(v[30:23]) - EXP_BIAS + 1023), v[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  // Round a double to binary32 nearest-even at unbounded exponent, then overflow/flush.
  function automatic logic [31:0] to_fp32(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int          e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + EXP_BIAS;
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      e++;
      m = m >> 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0)   return {d[63], 31'h0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b_in, input logic neg);
    logic [31:0] b;
    real         r;
    b = {b_in[31] ^ neg, b_in[30:0]};
    if (is_nan(a) || is_nan(b)) return FP32_QNAN;
    if (is_inf(a) && is_inf(b)) return (a[31] == b[31]) ? a : FP32_QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'h0};
    r = to_real(a) + to_real(b);
    if (r == 0.0) return 32'h0;
    return to_fp32(r);
  endfunction

  // Returns {equal, greater}.
  function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    if (is_nan(a) || is_nan(b)) return 2'b00;
    ra = to_real(a);
    rb = to_real(b);
    if (ra == rb) return 2'b10;
    if (ra > rb)  return 2'b01;
    return 2'b00;
  endfunction

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic comp);
    fpu_if.a    = a;
    fpu_if.b    = b;
    fpu_if.sub  = sub;
    fpu_if.comp = comp;
`ifdef FPU_ADDSUB_OUT_REG_EN
    @(posedge clock);
    #1;
`else
    #1;
`endif
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic comp);
    apply(a, b, sub, comp);
    check_val({tag, "_y"}, fpu_if.y, ref_add(a, b, sub | comp));
    check_val({tag, "_flags"}, {30'h0, fpu_if.a_equal_b, fpu_if.a_hi_b},
              {30'h0, comp ? ref_cmp(a, b) : 2'b00});
  endtask

  function automatic logic [31:0] rand_op(input logic [7:0] near);
    logic [31:0] v;
    int          e;
    v = $urandom;
    case ($urandom_range(0, 15))
      0:          begin v[30:23] = 8'h00; if ($urandom_range(0, 1) == 1) v[22:0] = 23'h0; end
      1:          v[30:0] = {8'hFF, 23'h0};
      2:          v[30:23] = 8'hFF;
      3:          v[30:23] = 8'hFE;
      4, 5, 6, 7, 8, 9: begin
        e = int'(near) + int'($urandom_range(0, 6)) - 3;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        v[30:23] = 8'(e);
      end
      default:    ;
    endcase
    return v;
  endfunction

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        comp;
    logic [31:0] y;
    logic [1:0]  flags;
  } vec_t;

  vec_t dir_tab[$] = '{
    '{"one_plus_two",  32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40400000, 2'b00},
    '{"x_minus_x",     32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 32'h00000000, 2'b00},
    '{"inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7FC00000, 2'b00},
    '{"tie_even",      32'h3F800000, 32'h33800000, 1'b0, 1'b0, 32'h3F800000, 2'b00},
    '{"tie_odd",       32'h3F800001, 32'h33800000, 1'b0, 1'b0, 32'h3F800002, 2'b00},
    '{"overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 2'b00},
    '{"cmp_gt",        32'h40000000, 32'h3F800000, 1'b0, 1'b1, 32'h3F800000, 2'b01},
    '{"cmp_lt",        32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'hBF800000, 2'b00},
    '{"cmp_zeros",     32'h00000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 2'b10},
    '{"cmp_neg",       32'hC0000000, 32'hBF800000, 1'b0, 1'b1, 32'hBF800000, 2'b00},
    '{"cmp_nan",       32'h7FC00000, 32'h3F800000, 1'b0, 1'b1, 32'h7FC00000, 2'b00},
    '{"cmp_infs",      32'h7F800000, 32'hFF800000, 1'b1, 1'b1, 32'h7F800000, 2'b01},
    '{"nzero_sum",     32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 2'b00},
    '{"mixed_zero",    32'h00000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 2'b00},
    '{"inf_plus_fin",  32'hFF800000, 32'h3F800000, 1'b0, 1'b0, 32'hFF800000, 2'b00},
    '{"subnorm_ftz",   32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 2'b00},
    '{"underflow",     32'h00800001, 32'h00800000, 1'b1, 1'b0, 32'h00000000, 2'b00}
  };

  initial begin
    logic [31:0] a, b;
    logic        sub, comp;

    reset = 1'b1;
    apply(32'h3F800000, 32'h40000000, 1'b0, 1'b1);
`ifdef FPU_ADDSUB_OUT_REG_EN
    check_val("reset_y", fpu_if.y, 32'h0);
    check_val("reset_flags", {30'h0, fpu_if.a_equal_b, fpu_if.a_hi_b}, 32'h0);
`else
    check_val("comb_under_reset_y", fpu_if.y, 32'hBF800000);
    check_val("comb_under_reset_flags", {30'h0, fpu_if.a_equal_b, fpu_if.a_hi_b}, 32'h0);
`endif
    reset = 1'b0;

    foreach (dir_tab[i]) begin
      apply(dir_tab[i].a, dir_tab[i].b, dir_tab[i].sub, dir_tab[i].comp);
      check_val({dir_tab[i].tag, "_y"}, fpu_if.y, dir_tab[i].y);
      check_val({dir_tab[i].tag, "_flags"}, {30'h0, fpu_if.a_equal_b, fpu_if.a_hi_b},
                {30'h0, dir_tab[i].flags});
    end

`ifdef FPU_ADDSUB_OUT_REG_EN
    fpu_if.a = 32'h3F800000;
    fpu_if.b = 32'h3F800000;
    fpu_if.comp = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_val("midop_reset_flags", {30'h0, fpu_if.a_equal_b, fpu_if.a_hi_b}, 32'h0);
`endif

    for (int i = 0; i < 32768; i++) begin
      a = rand_op(8'($urandom_range(1, 254)));
      case ($urandom_range(0, 9))
        0:       b = a;
        1:       b = a ^ 32'h80000000;
        default: b = rand_op(a[30:23]);
      endcase
      sub  = 1'($urandom_range(0, 1));
      comp = ($urandom_range(0, 3) == 0);
      run_vec("rand", a, b, sub, comp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
